// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle MIPS control FSM.
// It drives the datapath register enables, the mux selects and the ALU operation.
// A wait counter holds FETCH and MEM_READ for MEM_WAIT extra cycles.
// Optional feature macro: MC_EXCEPTION_EN. When it is defined, illegal instructions and signed
// add/sub overflow trap to EXC, which captures the EPC.
// Parameters: MEM_WAIT   memory read latency in extra cycles (0..15)
// Inputs:     clock, reset (async, active-high), opcode/funct (IR fields), zero_flag,
//             overflow_flag
// Outputs:    datapath enables/selects, pc_source/alu_src_b/mem_to_reg (2b), alu_op (3b),
//             state_out (4b state code), halted
module mc_control_unit #(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero_flag,
   input  logic       overflow_flag,
   output logic       pc_write,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       alu_src_a,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       a_write,
   output logic       b_write,
   output logic       aluout_write,
   output logic       mdr_write,
   output logic       epc_write,
   output logic [1:0] pc_source,
   output logic [1:0] alu_src_b,
   output logic [1:0] mem_to_reg,
   output logic [2:0] alu_op,
   output logic [3:0] state_out,
   output logic       halted
);

   localparam int unsigned WCNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
   localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(MEM_WAIT);

   localparam logic [2:0] AluAdd = 3'd1;
   localparam logic [2:0] AluSub = 3'd2;
   localparam logic [2:0] AluAnd = 3'd3;
   localparam logic [2:0] AluXor = 3'd6;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StAritExec = 4'd2,
      StAritWb   = 4'd3,
      StMemAddr  = 4'd4,
      StMemRead  = 4'd5,
      StMemWb    = 4'd6,
      StMemWrite = 4'd7,
      StLui      = 4'd8,
      StJump     = 4'd9,
      StBranch   = 4'd10,
      StHalt     = 4'd11,
      StExc      = 4'd12
   } state_e;

   state_e            state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              is_arith;
   logic [2:0]        arith_op;
   state_e            illegal_next;

`ifdef MC_EXCEPTION_EN
   assign illegal_next = StExc;
`else
   assign illegal_next = StFetch;
   logic unused_overflow;
   assign unused_overflow = overflow_flag;
`endif

   // R-type funct decode; the IR stays stable, so ARIT_WB can reuse it.
   always_comb begin
      is_arith = 1'b1;
      arith_op = AluAdd;
      case (funct)
         6'h20:   arith_op = AluAdd;
         6'h22:   arith_op = AluSub;
         6'h24:   arith_op = AluAnd;
         6'h26:   arith_op = AluXor;
         default: is_arith = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
         wcnt_q  <= WAIT_INIT;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_write     = 1'b0;
      iord         = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      alu_src_a    = 1'b0;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      a_write      = 1'b0;
      b_write      = 1'b0;
      aluout_write = 1'b0;
      mdr_write    = 1'b0;
      epc_write    = 1'b0;
      pc_source    = 2'b00;
      alu_src_b    = 2'b00;
      mem_to_reg   = 2'b00;
      alu_op       = 3'd0;
      halted       = 1'b0;
      case (state_q)
         StFetch: begin
            alu_src_b = 2'b01;
            alu_op    = AluAdd;
            if (wcnt_q == '0) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end
         end
         StDecode: begin
            a_write      = 1'b1;
            b_write      = 1'b1;
            aluout_write = 1'b1;
            alu_src_b    = 2'b11;
            alu_op       = AluAdd;
            if (opcode == 6'h00 && is_arith)           state_d = StAritExec;
            else if (opcode == 6'h00 && funct == 6'h00) state_d = StFetch;
            else if (opcode == 6'h00 && funct == 6'h0d) state_d = StHalt;
            else begin
               case (opcode)
                  6'h23, 6'h2b: state_d = StMemAddr;
                  6'h0f:        state_d = StLui;
                  6'h02:        state_d = StJump;
                  6'h04, 6'h05: state_d = StBranch;
                  default:      state_d = illegal_next;
               endcase
            end
         end
         StAritExec: begin
            alu_src_a    = 1'b1;
            aluout_write = 1'b1;
            alu_op       = arith_op;
            state_d      = StAritWb;
`ifdef MC_EXCEPTION_EN
            if ((funct == 6'h20 || funct == 6'h22) && overflow_flag) state_d = StExc;
`endif
         end
         StAritWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            alu_op    = arith_op;
            state_d   = StFetch;
         end
         StMemAddr: begin
            alu_src_a    = 1'b1;
            alu_src_b    = 2'b10;
            alu_op       = AluAdd;
            aluout_write = 1'b1;
            state_d      = (opcode == 6'h23) ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            iord = 1'b1;
            if (wcnt_q == '0) begin
               mdr_write = 1'b1;
               state_d   = StMemWb;
            end
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            state_d    = StFetch;
         end
         StMemWrite: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            state_d   = StFetch;
         end
         StLui: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
            state_d    = StFetch;
         end
         StJump: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = StFetch;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            alu_op    = AluSub;
            pc_source = 2'b01;
            pc_write  = (opcode == 6'h04 && zero_flag) || (opcode == 6'h05 && !zero_flag);
            state_d   = StFetch;
         end
         StHalt: begin
            halted = 1'b1;
         end
`ifdef MC_EXCEPTION_EN
         StExc: begin
            epc_write = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = AluSub;
            pc_write  = 1'b1;
            pc_source = 2'b11;
            state_d   = StFetch;
         end
`endif
         default: state_d = StFetch;
      endcase

      // Counter is reloaded on entry to a wait state and counts down while dwelling there.
      wcnt_d = wcnt_q;
      if ((state_q == StFetch || state_q == StMemRead) && wcnt_q != '0) begin
         wcnt_d = wcnt_q - WCNT_W'(1);
      end else if (state_d == StFetch || state_d == StMemRead) begin
         wcnt_d = WAIT_INIT;
      end

      // Async reset holds state at FETCH, which would otherwise fire with MEM_WAIT=0.
      if (reset) begin
         pc_write     = 1'b0;
         ir_write     = 1'b0;
         reg_write    = 1'b0;
         mem_write    = 1'b0;
         epc_write    = 1'b0;
         a_write      = 1'b0;
         b_write      = 1'b0;
         aluout_write = 1'b0;
         mdr_write    = 1'b0;
      end
   end

   assign state_out = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit.
// It instantiates two copies of the design: one with MEM_WAIT=2 and one with MEM_WAIT=0.
module tb_mc_control_unit;

   logic       clock;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero_flag;
   logic       overflow_flag;

   logic       pc_write, iord, mem_write, ir_write, alu_src_a, reg_write, reg_dst;
   logic       a_write, b_write, aluout_write, mdr_write, epc_write, halted;
   logic [1:0] pc_source, alu_src_b, mem_to_reg;
   logic [2:0] alu_op;
   logic [3:0] state_out;

   logic       w0_pc_write, w0_iord, w0_mem_write, w0_ir_write, w0_alu_src_a, w0_reg_write;
   logic       w0_reg_dst, w0_a_write, w0_b_write, w0_aluout_write, w0_mdr_write;
   logic       w0_epc_write, w0_halted;
   logic [1:0] w0_pc_source, w0_alu_src_b, w0_mem_to_reg;
   logic [2:0] w0_alu_op;
   logic [3:0] w0_state_out;

   int errors = 0;
   int checks = 0;

   mc_control_unit #(.MEM_WAIT(2)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
      .zero_flag(zero_flag), .overflow_flag(overflow_flag),
      .pc_write(pc_write), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .alu_src_a(alu_src_a), .reg_write(reg_write), .reg_dst(reg_dst), .a_write(a_write),
      .b_write(b_write), .aluout_write(aluout_write), .mdr_write(mdr_write),
      .epc_write(epc_write), .pc_source(pc_source), .alu_src_b(alu_src_b),
      .mem_to_reg(mem_to_reg), .alu_op(alu_op), .state_out(state_out), .halted(halted)
   );

   mc_control_unit #(.MEM_WAIT(0)) dut0 (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
      .zero_flag(zero_flag), .overflow_flag(overflow_flag),
      .pc_write(w0_pc_write), .iord(w0_iord), .mem_write(w0_mem_write),
      .ir_write(w0_ir_write), .alu_src_a(w0_alu_src_a), .reg_write(w0_reg_write),
      .reg_dst(w0_reg_dst), .a_write(w0_a_write), .b_write(w0_b_write),
      .aluout_write(w0_aluout_write), .mdr_write(w0_mdr_write), .epc_write(w0_epc_write),
      .pc_source(w0_pc_source), .alu_src_b(w0_alu_src_b), .mem_to_reg(w0_mem_to_reg),
      .alu_op(w0_alu_op), .state_out(w0_state_out), .halted(w0_halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Called on a falling edge; returns on the next falling edge with FETCH freshly entered.
   task automatic apply_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++;
      if (state_out !== 4'd0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got state=%0d halted=%0b want 0/0", state_out, halted);
      end
      checks++;
      if ({pc_write, ir_write, reg_write, mem_write, epc_write, a_write, b_write,
           aluout_write, mdr_write} !== 9'b0) begin
         errors++;
         $display("FAIL reset_enables: got nonzero write enable want all 0");
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_add();
      int exp_st[7] = '{0, 0, 0, 1, 2, 3, 0};
      apply_reset();
      opcode = 6'h00; funct = 6'h20; zero_flag = 1'b0; overflow_flag = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #1;
         checks++;
         if (state_out !== 4'(exp_st[i])) begin
            errors++;
            $display("FAIL add_state[%0d]: got %0d want %0d", i, state_out, exp_st[i]);
         end
         checks++;
         if (ir_write !== 1'(i == 2)) begin
            errors++;
            $display("FAIL add_ir_write[%0d]: got %0b want %0b", i, ir_write, (i == 2));
         end
         if (i == 4) begin
            checks++;
            if (alu_op !== 3'd1 || alu_src_a !== 1'b1 || aluout_write !== 1'b1) begin
               errors++;
               $display("FAIL add_exec: got op=%0d src_a=%0b aluout=%0b want 1/1/1",
                        alu_op, alu_src_a, aluout_write);
            end
         end
         if (i == 5) begin
            checks++;
            if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 2'b00) begin
               errors++;
               $display("FAIL add_wb: got rw=%0b rd=%0b m2r=%0d want 1/1/0",
                        reg_write, reg_dst, mem_to_reg);
            end
         end
         @(negedge clock);
      end
   endtask

   task automatic test_lw();
      int exp_st[10] = '{0, 0, 0, 1, 4, 5, 5, 5, 6, 0};
      apply_reset();
      opcode = 6'h23; funct = 6'h00;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if (state_out !== 4'(exp_st[i])) begin
            errors++;
            $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_out, exp_st[i]);
         end
         checks++;
         if (mdr_write !== 1'(i == 7)) begin
            errors++;
            $display("FAIL lw_mdr_write[%0d]: got %0b want %0b", i, mdr_write, (i == 7));
         end
         if (i == 8) begin
            checks++;
            if (reg_write !== 1'b1 || mem_to_reg !== 2'b01 || reg_dst !== 1'b0) begin
               errors++;
               $display("FAIL lw_wb: got rw=%0b m2r=%0d rd=%0b want 1/1/0",
                        reg_write, mem_to_reg, reg_dst);
            end
         end
         @(negedge clock);
      end
   endtask

   task automatic test_branch();
      logic [5:0] ops[4] = '{6'h04, 6'h05, 6'h05, 6'h04};
      logic       zs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic       pws[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      int exp_st[6] = '{0, 0, 0, 1, 10, 0};
      for (int v = 0; v < 4; v++) begin
         apply_reset();
         opcode = ops[v]; funct = 6'h00; zero_flag = zs[v];
         for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (state_out !== 4'(exp_st[i])) begin
               errors++;
               $display("FAIL br%0d_state[%0d]: got %0d want %0d", v, i, state_out, exp_st[i]);
            end
            if (i == 4) begin
               checks++;
               if (pc_write !== pws[v] || pc_source !== 2'b01 || alu_op !== 3'd2) begin
                  errors++;
                  $display("FAIL br%0d_pc: got pw=%0b src=%0d op=%0d want %0b/1/2",
                           v, pc_write, pc_source, alu_op, pws[v]);
               end
            end
            @(negedge clock);
         end
      end
      zero_flag = 1'b0;
   endtask

   task automatic test_jump_lui();
      logic [5:0] ops[2] = '{6'h02, 6'h0f};
      int sts[2] = '{9, 8};
      for (int v = 0; v < 2; v++) begin
         apply_reset();
         opcode = ops[v]; funct = 6'h00;
         repeat (4) @(negedge clock);
         #1;
         checks++;
         if (state_out !== 4'(sts[v])) begin
            errors++;
            $display("FAIL jl%0d_state: got %0d want %0d", v, state_out, sts[v]);
         end
         checks++;
         if (v == 0 && (pc_write !== 1'b1 || pc_source !== 2'b10 || reg_write !== 1'b0)) begin
            errors++;
            $display("FAIL jump_out: got pw=%0b src=%0d rw=%0b want 1/2/0",
                     pc_write, pc_source, reg_write);
         end else if (v == 1 && (reg_write !== 1'b1 || mem_to_reg !== 2'b10 ||
                                 reg_dst !== 1'b0 || pc_write !== 1'b0)) begin
            errors++;
            $display("FAIL lui_out: got rw=%0b m2r=%0d rd=%0b pw=%0b want 1/2/0/0",
                     reg_write, mem_to_reg, reg_dst, pc_write);
         end
         @(negedge clock);
         #1;
         checks++;
         if (state_out !== 4'd0) begin
            errors++;
            $display("FAIL jl%0d_return: got %0d want 0", v, state_out);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_halt();
      int exp;
      apply_reset();
      opcode = 6'h00; funct = 6'h0d;
      for (int i = 0; i < 26; i++) begin
         exp = (i < 3) ? 0 : (i == 3) ? 1 : 11;
         #1;
         checks++;
         if (state_out !== 4'(exp) || halted !== 1'(i >= 4)) begin
            errors++;
            $display("FAIL halt[%0d]: got state=%0d halted=%0b want %0d/%0b",
                     i, state_out, halted, exp, (i >= 4));
         end
         if (i >= 4) begin
            checks++;
            if (pc_write !== 1'b0 || reg_write !== 1'b0 || ir_write !== 1'b0) begin
               errors++;
               $display("FAIL halt_en[%0d]: got pw=%0b rw=%0b iw=%0b want 0", i,
                        pc_write, reg_write, ir_write);
            end
         end
         @(negedge clock);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (state_out !== 4'd0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_reset: got state=%0d halted=%0b want 0/0", state_out, halted);
      end
      @(negedge clock);
      reset = 1'b0;
      funct = 6'h00;
   endtask

   task automatic test_illegal();
`ifdef MC_EXCEPTION_EN
      int exp_st[6] = '{0, 0, 0, 1, 12, 0};
      int n = 6;
`else
      int exp_st[6] = '{0, 0, 0, 1, 0, 0};
      int n = 5;
`endif
      apply_reset();
      opcode = 6'h3f; funct = 6'h00;
      for (int i = 0; i < n; i++) begin
         #1;
         checks++;
         if (state_out !== 4'(exp_st[i])) begin
            errors++;
            $display("FAIL ill_state[%0d]: got %0d want %0d", i, state_out, exp_st[i]);
         end
         checks++;
`ifdef MC_EXCEPTION_EN
         if (epc_write !== 1'(i == 4) || (i == 4 && pc_source !== 2'b11)) begin
`else
         if (epc_write !== 1'b0 || pc_source === 2'b11) begin
`endif
            errors++;
            $display("FAIL ill_epc[%0d]: got epc=%0b src=%0d", i, epc_write, pc_source);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_overflow();
`ifdef MC_EXCEPTION_EN
      int exp_st[7] = '{0, 0, 0, 1, 2, 12, 0};
`else
      int exp_st[7] = '{0, 0, 0, 1, 2, 3, 0};
`endif
      apply_reset();
      opcode = 6'h00; funct = 6'h20; overflow_flag = 1'b1;
      for (int i = 0; i < 7; i++) begin
         #1;
         checks++;
         if (state_out !== 4'(exp_st[i])) begin
            errors++;
            $display("FAIL ovf_state[%0d]: got %0d want %0d", i, state_out, exp_st[i]);
         end
         if (i == 5) begin
            checks++;
`ifdef MC_EXCEPTION_EN
            if (reg_write !== 1'b0 || epc_write !== 1'b1 || pc_source !== 2'b11 ||
                pc_write !== 1'b1) begin
               errors++;
               $display("FAIL ovf_exc: got rw=%0b epc=%0b src=%0d pw=%0b want 0/1/3/1",
                        reg_write, epc_write, pc_source, pc_write);
            end
`else
            if (reg_write !== 1'b1 || epc_write !== 1'b0) begin
               errors++;
               $display("FAIL ovf_ignored: got rw=%0b epc=%0b want 1/0", reg_write, epc_write);
            end
`endif
         end
         @(negedge clock);
      end
      overflow_flag = 1'b0;
   endtask

   task automatic test_wait0();
      int exp_st[5] = '{0, 1, 4, 7, 0};
      reset = 1'b1;
      #1;
      checks++;
      if (w0_pc_write !== 1'b0 || w0_ir_write !== 1'b0 || w0_state_out !== 4'd0) begin
         errors++;
         $display("FAIL w0_reset: got pw=%0b iw=%0b state=%0d want 0/0/0",
                  w0_pc_write, w0_ir_write, w0_state_out);
      end
      @(negedge clock);
      reset = 1'b0;
      opcode = 6'h2b; funct = 6'h00;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (w0_state_out !== 4'(exp_st[i])) begin
            errors++;
            $display("FAIL w0_state[%0d]: got %0d want %0d", i, w0_state_out, exp_st[i]);
         end
         checks++;
         if (w0_mem_write !== 1'(i == 3)) begin
            errors++;
            $display("FAIL w0_mem_write[%0d]: got %0b want %0b", i, w0_mem_write, (i == 3));
         end
         if (i == 0) begin
            checks++;
            if (w0_pc_write !== 1'b1 || w0_ir_write !== 1'b1) begin
               errors++;
               $display("FAIL w0_fetch: got pw=%0b iw=%0b want 1/1", w0_pc_write, w0_ir_write);
            end
         end
         @(negedge clock);
      end
   endtask

   initial begin
      reset = 1'b1;
      opcode = 6'h00;
      funct = 6'h00;
      zero_flag = 1'b0;
      overflow_flag = 1'b0;
      repeat (2) @(negedge clock);
      test_reset();
      test_add();
      test_lw();
      test_branch();
      test_jump_lui();
      test_halt();
      test_illegal();
      test_overflow();
      test_wait0();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
